// File: rtl/reg_cpu_arbiter.sv
// Round-robin arbiter sharing one register bus among N_REQ masters, with a
// per-access timeout so a silent slave cannot hang the bus.
module reg_cpu_arbiter #(
    parameter int N_REQ   = 2,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_i,
    input  logic [N_REQ-1:0]        req_we_i,
    input  logic [N_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [N_REQ*DATA_W-1:0] req_wdata_i,
    output logic [N_REQ-1:0]        ack_o,
    output logic [N_REQ-1:0]        err_o,
    output logic [DATA_W-1:0]       rdata_o,
    output logic                    reg_cs,
    output logic                    reg_we,
    output logic [ADDR_W-1:0]       reg_addr,
    output logic [DATA_W-1:0]       reg_wdata,
    input  logic [DATA_W-1:0]       reg_rdata,
    input  logic                    reg_ack,
    output logic [1:0]              o_dbg_state
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int TMR_W = $clog2(TIMEOUT);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);
    localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT - 1);

    // Handshake: a master holds req_i[k] with stable we/addr/wdata until it
    // sees the one-cycle ack_o[k]; the slave holds nothing and answers with
    // a one-cycle reg_ack while reg_cs is high.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state,  w_state_nxt;
    logic [IDX_W-1:0]   r_last,   w_last_nxt;
    logic [IDX_W-1:0]   r_idx,    w_idx_nxt;
    logic [TMR_W-1:0]   r_timer,  w_timer_nxt;
    logic               r_cs,     w_cs_nxt;
    logic               r_we,     w_we_nxt;
    logic [ADDR_W-1:0]  r_addr,   w_addr_nxt;
    logic [DATA_W-1:0]  r_wdata,  w_wdata_nxt;
    logic [N_REQ-1:0]   r_ack,    w_ack_nxt;
    logic [N_REQ-1:0]   r_err,    w_err_nxt;
    logic [DATA_W-1:0]  r_rdata,  w_rdata_nxt;
    logic [IDX_W-1:0]   w_win;
    logic               w_any;

    // Search starts one past the last owner so every master gets a turn.
    always_comb begin
        int c;
        w_win = '0;
        w_any = 1'b0;
        c     = 0;
        for (int i = 0; i < N_REQ; i++) begin
            c = int'(r_last) + 1 + i;
            if (c >= N_REQ) c = c - N_REQ;
            if (!w_any && req_i[IDX_W'(c)]) begin
                w_any = 1'b1;
                w_win = IDX_W'(c);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_idx_nxt   = r_idx;
        w_timer_nxt = r_timer;
        w_cs_nxt    = r_cs;
        w_we_nxt    = r_we;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_ack_nxt   = '0;
        w_err_nxt   = '0;
        w_rdata_nxt = r_rdata;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_idx_nxt   = w_win;
                    w_we_nxt    = req_we_i[w_win];
                    w_addr_nxt  = req_addr_i[w_win*ADDR_W +: ADDR_W];
                    w_wdata_nxt = req_wdata_i[w_win*DATA_W +: DATA_W];
                    w_cs_nxt    = 1'b1;
                    w_timer_nxt = '0;
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                // An ack in the final timer cycle still counts as success.
                if (reg_ack) begin
                    w_rdata_nxt      = reg_rdata;
                    w_ack_nxt[r_idx] = 1'b1;
                    w_cs_nxt         = 1'b0;
                    w_state_nxt      = S_DONE;
                end else if (r_timer == TMR_MAX) begin
                    w_rdata_nxt      = '0;
                    w_ack_nxt[r_idx] = 1'b1;
                    w_err_nxt[r_idx] = 1'b1;
                    w_cs_nxt         = 1'b0;
                    w_state_nxt      = S_DONE;
                end else begin
                    w_timer_nxt = r_timer + TMR_W'(1);
                end
            end
            S_DONE: begin
                w_last_nxt  = r_idx;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_last  <= LAST_RST;
            r_idx   <= '0;
            r_timer <= '0;
            r_cs    <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_ack   <= '0;
            r_err   <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
            r_idx   <= w_idx_nxt;
            r_timer <= w_timer_nxt;
            r_cs    <= w_cs_nxt;
            r_we    <= w_we_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
            r_ack   <= w_ack_nxt;
            r_err   <= w_err_nxt;
            r_rdata <= w_rdata_nxt;
        end
    end

    assign ack_o       = r_ack;
    assign err_o       = r_err;
    assign rdata_o     = r_rdata;
    assign reg_cs      = r_cs;
    assign reg_we      = r_we;
    assign reg_addr    = r_addr;
    assign reg_wdata   = r_wdata;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_reg_cpu_arbiter.sv
// Bench for reg_cpu_arbiter: vector table of contention/latency scenarios,
// round-robin reference model feeding expected queues, plus reset/ack corners.
module tb_reg_cpu_arbiter;

    localparam int N_REQ   = 4;
    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 8;
    localparam int DN_W    = 1 + ADDR_W + DATA_W;
    localparam int CP_W    = N_REQ + 1 + DATA_W + 8 + 1;

    logic                    clk;
    logic                    rst_n;
    logic [N_REQ-1:0]        req_i;
    logic [N_REQ-1:0]        req_we_i;
    logic [N_REQ*ADDR_W-1:0] req_addr_i;
    logic [N_REQ*DATA_W-1:0] req_wdata_i;
    logic [N_REQ-1:0]        ack_o;
    logic [N_REQ-1:0]        err_o;
    logic [DATA_W-1:0]       rdata_o;
    logic                    reg_cs;
    logic                    reg_we;
    logic [ADDR_W-1:0]       reg_addr;
    logic [DATA_W-1:0]       reg_wdata;
    logic [DATA_W-1:0]       reg_rdata;
    logic                    reg_ack;
    logic [1:0]              o_dbg_state;

    reg_cpu_arbiter #(
        .N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .req_we_i(req_we_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .ack_o(ack_o), .err_o(err_o), .rdata_o(rdata_o),
        .reg_cs(reg_cs), .reg_we(reg_we), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .reg_ack(reg_ack),
        .o_dbg_state(o_dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int model_last = N_REQ - 1;

    logic [DN_W-1:0] dn_exp_q[$];
    logic [CP_W-1:0] cp_exp_q[$];

    typedef struct {
        logic [N_REQ-1:0]  mask;
        int                nx;
        logic              we;
        int                delay;
        logic [DATA_W-1:0] data;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic fail_event(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got unexpected event expected none", name);
    endtask

    // Drives one vector: every masked requester issues v.nx transactions,
    // slave acks in reg_cs cycle v.delay+1 (never if beyond TIMEOUT).
    task automatic run_vector(input vec_t v, input int vno);
        logic [ADDR_W-1:0] t_addr[N_REQ][2];
        logic [DATA_W-1:0] t_wdata[N_REQ][2];
        logic [DATA_W-1:0] slv_rd[16];
        int rem[N_REQ];
        int sent[N_REQ];
        int rr[N_REQ];
        int total, mlast, cc, j, cslen;
        int done, cyc, cs_cnt, grant_no, last_rise, last_cs_len, dropped;
        logic exp_err, prev_cs, fell, found;
        logic [N_REQ-1:0] oh;
        logic [DN_W-1:0] e;
        logic [CP_W-1:0] c;

        total = 0;
        for (int k = 0; k < N_REQ; k++) begin
            rem[k]  = v.mask[k] ? v.nx : 0;
            rr[k]   = rem[k];
            sent[k] = 0;
            total   = total + rem[k];
            for (int x = 0; x < 2; x++) begin
                t_addr[k][x]  = ADDR_W'((vno << 8) | (k << 4) | x);
                t_wdata[k][x] = $urandom;
            end
        end

        // reference round-robin: expected grant order into the queues
        exp_err = (v.delay > TIMEOUT - 1);
        cslen   = exp_err ? TIMEOUT : v.delay + 1;
        mlast   = model_last;
        for (int g = 0; g < total; g++) begin
            found = 1'b0;
            cc = 0;
            for (int i = 1; i <= N_REQ; i++) begin
                if (!found && rr[(mlast + i) % N_REQ] > 0) begin
                    found = 1'b1;
                    cc = (mlast + i) % N_REQ;
                end
            end
            j = v.nx - rr[cc];
            slv_rd[g] = v.data ^ (DATA_W'(g) * 32'h0101_0101);
            oh = N_REQ'(1) << cc;
            dn_exp_q.push_back({v.we, t_addr[cc][j], t_wdata[cc][j]});
            cp_exp_q.push_back({oh, exp_err, exp_err ? '0 : slv_rd[g], 8'(cslen), ~v.we});
            rr[cc]--;
            mlast = cc;
        end
        model_last = mlast;

        done = 0; cyc = 0; cs_cnt = 0; grant_no = 0;
        last_rise = -1; last_cs_len = 0; prev_cs = reg_cs;
        while (done < total && cyc < 400) begin
            @(negedge clk);
            cyc++;
            fell = 1'b0;
            if (reg_cs && !prev_cs) begin
                if (dn_exp_q.size() == 0) begin
                    fail_event("dn_unexpected_cs");
                end else begin
                    e = dn_exp_q.pop_front();
                    check("reg_we", 64'(reg_we), 64'(e[DN_W-1]));
                    check("reg_addr", 64'(reg_addr), 64'(e[DATA_W +: ADDR_W]));
                    check("reg_wdata", 64'(reg_wdata), 64'(e[DATA_W-1:0]));
                end
                if (last_rise >= 0) check("cs_rise_gap", 64'(cyc - last_rise), 64'(last_cs_len + 2));
                last_rise = cyc;
                cs_cnt = 1;
            end else if (reg_cs) begin
                cs_cnt++;
            end else if (prev_cs) begin
                last_cs_len = cs_cnt;
                grant_no++;
                fell = 1'b1;
            end

            // slave model
            reg_ack   = reg_cs && (cs_cnt == v.delay + 1);
            reg_rdata = (reg_ack && grant_no < 16) ? slv_rd[grant_no] : DATA_W'($urandom);

            // completion scoreboard and requester drivers
            dropped = -1;
            if (ack_o != '0) begin
                if (cp_exp_q.size() == 0) begin
                    fail_event("ack_unexpected");
                end else begin
                    c = cp_exp_q.pop_front();
                    oh = c[CP_W-1 -: N_REQ];
                    check("ack_o", 64'(ack_o), 64'(oh));
                    check("err_o", 64'(err_o), 64'(c[DATA_W+9] ? oh : '0));
                    check("cs_len", 64'(last_cs_len), 64'(c[8:1]));
                    check("ack_after_cs", 64'(fell), 64'(1));
                    if (c[0] || c[DATA_W+9])
                        check("rdata_o", 64'(rdata_o), 64'(c[DATA_W+8:9]));
                end
                done++;
                for (int k = 0; k < N_REQ; k++) begin
                    if (ack_o[k] && req_i[k] && dropped < 0) begin
                        req_i[k] = 1'b0;
                        rem[k]--;
                        sent[k]++;
                        dropped = k;
                    end
                end
            end
            for (int k = 0; k < N_REQ; k++) begin
                if (!req_i[k] && rem[k] > 0 && k != dropped) begin
                    req_i[k]    = 1'b1;
                    req_we_i[k] = v.we;
                    req_addr_i[k*ADDR_W +: ADDR_W]  = t_addr[k][sent[k]];
                    req_wdata_i[k*DATA_W +: DATA_W] = t_wdata[k][sent[k]];
                end
            end
            prev_cs = reg_cs;
        end
        if (done < total) begin
            n_checks++;
            n_fail++;
            $display("FAIL vector_%0d_timeout: got %0d completions expected %0d", vno, done, total);
        end
        check("queues_drained", 64'(dn_exp_q.size() + cp_exp_q.size()), 64'(0));
        dn_exp_q.delete();
        cp_exp_q.delete();
        reg_ack = 1'b0;
        req_i   = '0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_reg_cs"}, 64'(reg_cs), 64'(0));
        check({tag, "_reg_we"}, 64'(reg_we), 64'(0));
        check({tag, "_reg_addr"}, 64'(reg_addr), 64'(0));
        check({tag, "_reg_wdata"}, 64'(reg_wdata), 64'(0));
        check({tag, "_ack_o"}, 64'(ack_o), 64'(0));
        check({tag, "_err_o"}, 64'(err_o), 64'(0));
        check({tag, "_rdata_o"}, 64'(rdata_o), 64'(0));
        check({tag, "_state"}, 64'(o_dbg_state), 64'(0));
    endtask

    initial begin
        vecs[0] = '{4'b0010, 1, 1'b0, 0,   32'hDEAD_BEEF};
        vecs[1] = '{4'b0111, 2, 1'b1, 0,   32'h1111_0000};
        vecs[2] = '{4'b0001, 1, 1'b0, 100, 32'h2222_0000};
        vecs[3] = '{4'b0001, 1, 1'b0, 7,   32'hCAFE_F00D};
        vecs[4] = '{4'b1000, 1, 1'b0, 6,   32'h4444_0000};
        vecs[5] = '{4'b1111, 1, 1'b0, 2,   DATA_W'($urandom)};
        vecs[6] = '{4'b1010, 2, 1'b1, 3,   DATA_W'($urandom)};
        vecs[7] = '{4'b0100, 1, 1'b1, 100, 32'h7777_0000};

        rst_n = 1'b0;
        req_i = '0; req_we_i = '0; req_addr_i = '0; req_wdata_i = '0;
        reg_rdata = '0; reg_ack = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("in_reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("after_reset");

        // spurious slave ack while idle must be ignored
        reg_ack = 1'b1;
        reg_rdata = 32'h1234_5678;
        @(negedge clk);
        reg_ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("spurious_ack_o", 64'(ack_o), 64'(0));
            check("spurious_rdata", 64'(rdata_o), 64'(0));
            check("spurious_state", 64'(o_dbg_state), 64'(0));
            check("spurious_cs", 64'(reg_cs), 64'(0));
        end

        for (int v = 0; v < 8; v++) run_vector(vecs[v], v);

        // reset in the middle of a busy access
        @(negedge clk);
        req_we_i[2] = 1'b0;
        req_addr_i[2*ADDR_W +: ADDR_W] = 16'h0A5A;
        req_i[2] = 1'b1;
        for (int i = 0; i < 20 && !reg_cs; i++) @(negedge clk);
        check("pre_reset_cs", 64'(reg_cs), 64'(1));
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_cs_async", 64'(reg_cs), 64'(0));
        check("reset_state_async", 64'(o_dbg_state), 64'(0));
        req_i = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_no_ack", 64'(ack_o), 64'(0));
        end
        rst_n = 1'b1;
        model_last = N_REQ - 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("post_reset_no_ack", 64'(ack_o), 64'(0));
            check("post_reset_cs", 64'(reg_cs), 64'(0));
        end
        run_vector('{4'b0101, 1, 1'b0, 1, 32'h5A5A_A5A5}, 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
